mmio_bus_router: RTL and testbench

//  Parametrised data-bus router between the CPU data port and NUM_SLAVES memory-mapped targets
//  (data memory, PDU MMIO, future peripherals). Decodes addr[DEC_HI:DEC_LO] against per-slave keys.

---
 rtl/mmio_bus_router_pkg.sv | 18 +
 rtl/mmio_bus_router_addr_decoder.sv | 35 +++
 rtl/mmio_bus_router.sv | 169 ++++++++++++++++
 tb/tb_mmio_bus_router.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_router_pkg.sv
// Shared definitions for the MMIO data-bus router: FSM encoding, strobe width helper and
// the well-known PDU MMIO decode key.
package mmio_bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [7:0] MMIO_KEY = 8'h7f;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mmio_bus_router_addr_decoder.sv
// Combinational address decoder: compares a decode field against packed per-slave keys and
// returns a one-hot select (lowest matching index wins) plus an unmapped flag.
module mmio_bus_router_addr_decoder
    import mmio_bus_router_pkg::*;
#(
    parameter int                          NUM_SLAVES = 4,
    parameter int                          KEY_W      = 8,
    parameter logic [NUM_SLAVES*KEY_W-1:0] KEYS       = '0,
    parameter bit                          DEFAULT_EN = 1'b1
) (
    input  logic [KEY_W-1:0]      field_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  unmapped_o
);

    always_comb begin
        sel_o      = '0;
        unmapped_o = 1'b0;
        // Scan downwards so the lowest matching index is the one left standing.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (KEYS[i*KEY_W +: KEY_W] == field_i) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
            end
        end
        if (sel_o == '0) begin
            if (DEFAULT_EN) begin
                sel_o[0] = 1'b1;
            end else begin
                unmapped_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bus_router.sv
// CPU data-port router to NUM_SLAVES memory-mapped targets: one outstanding req/ack
// transaction, wait-state timeout, error response and sticky error reporting.
module mmio_bus_router
    import mmio_bus_router_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEC_HI     = 15,
    parameter int DEC_LO     = 8,
    parameter logic [NUM_SLAVES*(DEC_HI-DEC_LO+1)-1:0] SLAVE_KEYS =
        {MMIO_KEY, 8'h40, 8'h20, 8'h00},
    parameter bit DEFAULT_EN = 1'b1,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [strb_w(DATA_W)-1:0]    m_wstrb,
    output logic                         m_ack,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_req,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [strb_w(DATA_W)-1:0]    s_wstrb,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic [ADDR_W-1:0]            err_addr,
    output logic [7:0]                   err_cnt
);

    localparam int         KEY_W     = DEC_HI - DEC_LO + 1;
    localparam int         STRB_W    = strb_w(DATA_W);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    state_e                state_q, state_d;
    logic [NUM_SLAVES-1:0] sel_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q;
    logic                  m_ack_q, m_err_q;
    logic [DATA_W-1:0]     m_rdata_q;
    logic [ADDR_W-1:0]     err_addr_q;
    logic [7:0]            err_cnt_q;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_unmapped;
    logic                  latch, capture, ack_hit;
    logic [DATA_W-1:0]     rdata_sel;

    mmio_bus_router_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .KEY_W      (KEY_W),
        .KEYS       (SLAVE_KEYS),
        .DEFAULT_EN (DEFAULT_EN)
    ) u_dec (
        .field_i    (m_addr[DEC_HI:DEC_LO]),
        .sel_o      (dec_sel),
        .unmapped_o (dec_unmapped)
    );

    assign ack_hit = |(s_ack & sel_q);

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rdata_sel = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The m_ack cycle still sees the old request held high; skip it.
                if (m_req && !m_ack_q) begin
                    latch   = 1'b1;
                    cnt_d   = '0;
                    state_d = dec_unmapped ? ST_ERR : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_hit) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_d == TIMEOUT_C) begin
                    state_d = ST_ERR;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            m_ack_q    <= 1'b0;
            m_err_q    <= 1'b0;
            m_rdata_q  <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_ack_q <= (state_q == ST_RESP) || (state_q == ST_ERR);
            m_err_q <= (state_q == ST_ERR);
            if (latch) begin
                sel_q   <= dec_sel;
                we_q    <= m_we;
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wstrb_q <= m_wstrb;
            end
            if (capture && !we_q) begin
                rdata_q <= rdata_sel;
            end
            // m_rdata only moves on the edge that raises m_ack.
            if (state_q == ST_RESP && !we_q) begin
                m_rdata_q <= rdata_q;
            end
            if (state_q == ST_ERR) begin
                if (!we_q) begin
                    m_rdata_q <= '0;
                end
                err_addr_q <= addr_q;
                err_cnt_q  <= sat_inc(err_cnt_q);
            end
        end
    end

    assign s_req    = (state_q == ST_BUSY) ? sel_q : '0;
    assign s_we     = we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;
    assign m_ack    = m_ack_q;
    assign m_err    = m_err_q;
    assign m_rdata  = m_rdata_q;
    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_mmio_bus_router.sv
// Self-checking bench for mmio_bus_router: a default-routing instance with a slave model and a
// strict-decode instance used for unmapped and error-counter scenarios.
module tb_mmio_bus_router;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEFAULT_EN=1
    logic        m_req_a = 1'b0, m_we_a = 1'b0;
    logic [31:0] m_addr_a = '0, m_wdata_a = '0;
    logic [3:0]  m_wstrb_a = '0;
    logic        m_ack_a, m_err_a;
    logic [31:0] m_rdata_a;
    logic [1:0]  s_req_a;
    logic        s_we_a;
    logic [31:0] s_addr_a, s_wdata_a;
    logic [3:0]  s_wstrb_a;
    logic [1:0]  s_ack_a;
    logic [63:0] s_rdata_a;
    logic [31:0] err_addr_a;
    logic [7:0]  err_cnt_a;

    // Instance B: DEFAULT_EN=0
    logic        m_req_b = 1'b0, m_we_b = 1'b0;
    logic [31:0] m_addr_b = '0, m_wdata_b = '0;
    logic [3:0]  m_wstrb_b = '0;
    logic        m_ack_b, m_err_b;
    logic [31:0] m_rdata_b;
    logic [1:0]  s_req_b;
    logic        s_we_b;
    logic [31:0] s_addr_b, s_wdata_b;
    logic [3:0]  s_wstrb_b;
    logic [1:0]  s_ack_b = '0;
    logic [63:0] s_rdata_b = '0;
    logic [31:0] err_addr_b;
    logic [7:0]  err_cnt_b;

    mmio_bus_router #(
        .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32), .DEC_HI(15), .DEC_LO(8),
        .SLAVE_KEYS({8'h7f, 8'h00}), .DEFAULT_EN(1'b1), .TIMEOUT(15)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .m_req(m_req_a), .m_we(m_we_a), .m_addr(m_addr_a),
        .m_wdata(m_wdata_a), .m_wstrb(m_wstrb_a), .m_ack(m_ack_a), .m_err(m_err_a),
        .m_rdata(m_rdata_a), .s_req(s_req_a), .s_we(s_we_a), .s_addr(s_addr_a),
        .s_wdata(s_wdata_a), .s_wstrb(s_wstrb_a), .s_ack(s_ack_a), .s_rdata(s_rdata_a),
        .err_addr(err_addr_a), .err_cnt(err_cnt_a)
    );

    mmio_bus_router #(
        .NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32), .DEC_HI(15), .DEC_LO(8),
        .SLAVE_KEYS({8'h7f, 8'h00}), .DEFAULT_EN(1'b0), .TIMEOUT(15)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .m_req(m_req_b), .m_we(m_we_b), .m_addr(m_addr_b),
        .m_wdata(m_wdata_b), .m_wstrb(m_wstrb_b), .m_ack(m_ack_b), .m_err(m_err_b),
        .m_rdata(m_rdata_b), .s_req(s_req_b), .s_we(s_we_b), .s_addr(s_addr_b),
        .s_wdata(s_wdata_b), .s_wstrb(s_wstrb_b), .s_ack(s_ack_b), .s_rdata(s_rdata_b),
        .err_addr(err_addr_b), .err_cnt(err_cnt_b)
    );

    // Slave model for instance A: ack after dly[i] s_req cycles unless noack[i].
    logic [1:0]  ack_m = '0, ack_x = '0;
    int          dly[2];
    bit          noack[2];
    int          wcnt[2];
    logic [31:0] rd0 = '0, rd1 = '0;
    assign s_ack_a   = ack_m | ack_x;
    assign s_rdata_a = {rd1, rd0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (s_req_a[i]) begin
                ack_m[i] = !noack[i] && (wcnt[i] == dly[i]);
                wcnt[i]  = wcnt[i] + 1;
            end else begin
                ack_m[i] = 1'b0;
                wcnt[i]  = 0;
            end
        end
    end

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_a[$];
    exp_t        sb_b[$];
    int          lat, sreq_cyc;
    logic [1:0]  sreq_or;
    bit          onehot_bad;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic [31:0] model_rdata = '0;

    task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic exp_err,
                         input logic [31:0] exp_rdata, input int budget);
        exp_t e;
        int   n;
        bit   got;
        e.err = exp_err;
        e.rdata = exp_rdata;
        sb_a.push_back(e);
        @(negedge clk);
        m_req_a = 1'b1; m_we_a = we; m_addr_a = addr; m_wdata_a = wdata; m_wstrb_a = strb;
        lat = 0; sreq_cyc = 0; sreq_or = '0; onehot_bad = 0; got = 0;
        for (n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (s_req_a !== 2'b00) begin
                sreq_cyc++;
                sreq_or |= s_req_a;
                if ($countones(s_req_a) != 1) onehot_bad = 1;
            end
            if (n == 1) begin
                obs_we = s_we_a; obs_addr = s_addr_a; obs_wdata = s_wdata_a; obs_wstrb = s_wstrb_a;
            end
            if (m_ack_a === 1'b1) begin
                got = 1;
                lat = n;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_wait_a: no m_ack within %0d cycles (addr %h), required one", budget, addr);
            void'(sb_a.pop_front());
        end else begin
            e = sb_a.pop_front();
            checks++;
            if ({m_err_a, m_rdata_a} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL resp_a: err/rdata=%b/%h, required %b/%h", m_err_a, m_rdata_a, e.err, e.rdata);
            end
            checks++;
            if (onehot_bad) begin
                errors++;
                $display("FAIL onehot_a: s_req had more than one bit set, required one-hot");
            end
            @(posedge clk); #1;
            checks++;
            if (m_ack_a !== 1'b0 || s_req_a !== 2'b00) begin
                errors++;
                $display("FAIL no_reaccept_a: m_ack=%b s_req=%b after ack, required 0/00", m_ack_a, s_req_a);
            end
        end
        m_req_a = 1'b0;
    endtask

    task automatic run_b(input logic [31:0] addr, input int budget);
        exp_t e;
        int   n;
        bit   got;
        e.err = 1'b1;
        e.rdata = '0;
        sb_b.push_back(e);
        @(negedge clk);
        m_req_b = 1'b1; m_we_b = 1'b0; m_addr_b = addr;
        lat = 0; sreq_or = '0; got = 0;
        for (n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            sreq_or |= s_req_b;
            if (m_ack_b === 1'b1) begin
                got = 1;
                lat = n;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_wait_b: no m_ack within %0d cycles (addr %h), required one", budget, addr);
            void'(sb_b.pop_front());
        end else begin
            e = sb_b.pop_front();
            checks++;
            if ({m_err_b, m_rdata_b} !== {e.err, e.rdata}) begin
                errors++;
                $display("FAIL resp_b: err/rdata=%b/%h, required %b/%h", m_err_b, m_rdata_b, e.err, e.rdata);
            end
            @(posedge clk); #1;
        end
        m_req_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_ack_a, m_err_a, s_req_a, s_we_a, m_rdata_a, s_addr_a, s_wdata_a, s_wstrb_a,
             err_addr_a, err_cnt_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: ack=%b err=%b s_req=%b rdata=%h err_cnt=%h, required all 0",
                     m_ack_a, m_err_a, s_req_a, m_rdata_a, err_cnt_a);
        end
        checks++;
        if ({m_ack_b, m_err_b, s_req_b, m_rdata_b, err_addr_b, err_cnt_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: ack=%b err=%b s_req=%b err_cnt=%h, required all 0",
                     m_ack_b, m_err_b, s_req_b, err_cnt_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        rd0 = 32'h1234_5678; dly[0] = 0;
        run_a(1'b0, 32'h0000_0010, '0, 4'h0, 1'b0, 32'h1234_5678, 20);
        model_rdata = 32'h1234_5678;
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL read_latency: %0d cycles, required 3", lat);
        end
        checks++;
        if (sreq_or !== 2'b01 || sreq_cyc != 1) begin
            errors++; $display("FAIL read_sreq: s_req=%b for %0d cycles, required 01 for 1", sreq_or, sreq_cyc);
        end
        checks++;
        if (obs_we !== 1'b0 || obs_addr !== 32'h0000_0010) begin
            errors++; $display("FAIL read_latch: s_we=%b s_addr=%h, required 0/00000010", obs_we, obs_addr);
        end
    endtask

    task automatic test_write();
        rd1 = 32'hDEAD_BEEF; dly[1] = 0;
        run_a(1'b1, 32'h0000_7f04, 32'h0000_00A5, 4'h1, 1'b0, model_rdata, 20);
        checks++;
        if (sreq_or !== 2'b10) begin
            errors++; $display("FAIL write_sreq: s_req=%b, required 10", sreq_or);
        end
        checks++;
        if (obs_we !== 1'b1 || obs_wdata !== 32'h0000_00A5 || obs_wstrb !== 4'h1) begin
            errors++;
            $display("FAIL write_latch: s_we=%b s_wdata=%h s_wstrb=%h, required 1/000000a5/1",
                     obs_we, obs_wdata, obs_wstrb);
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL write_latency: %0d cycles, required 3", lat);
        end
    endtask

    task automatic test_timeout();
        noack[1] = 1;
        run_a(1'b0, 32'h0000_7f04, '0, 4'h0, 1'b1, 32'h0, 40);
        model_rdata = '0;
        checks++;
        if (sreq_cyc != 15 || sreq_or !== 2'b10) begin
            errors++; $display("FAIL timeout_sreq: s_req=%b for %0d cycles, required 10 for 15", sreq_or, sreq_cyc);
        end
        checks++;
        if (lat != 17) begin
            errors++; $display("FAIL timeout_latency: %0d cycles, required 17", lat);
        end
        checks++;
        if (err_addr_a !== 32'h0000_7f04 || err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL timeout_errinfo: err_addr=%h err_cnt=%0d, required 00007f04/1", err_addr_a, err_cnt_a);
        end
    endtask

    task automatic test_late_ack();
        int bad = 0;
        @(negedge clk);
        ack_x = 2'b10;
        repeat (3) begin
            @(posedge clk); #1;
            if (m_ack_a !== 1'b0 || s_req_a !== 2'b00) bad++;
        end
        ack_x = 2'b00;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL late_ack: %0d cycles with m_ack/s_req activity, required 0", bad);
        end
        checks++;
        if (err_cnt_a !== 8'd1) begin
            errors++; $display("FAIL late_ack_errcnt: err_cnt=%0d, required 1", err_cnt_a);
        end
        noack[1] = 0;
    endtask

    task automatic test_unmapped();
        run_b(32'h0000_3000, 20);
        checks++;
        if (lat != 2 || sreq_or !== 2'b00) begin
            errors++; $display("FAIL unmapped: latency %0d s_req=%b, required 2/00", lat, sreq_or);
        end
        checks++;
        if (err_addr_b !== 32'h0000_3000 || err_cnt_b !== 8'd1) begin
            errors++; $display("FAIL unmapped_errinfo: err_addr=%h err_cnt=%0d, required 00003000/1", err_addr_b, err_cnt_b);
        end
    endtask

    task automatic test_back_to_back();
        rd1 = 32'hCAFE_F00D; dly[1] = 2;
        rd0 = 32'h0BAD_F00D; dly[0] = 0;
        run_a(1'b0, 32'h0000_7f00, '0, 4'h0, 1'b0, 32'hCAFE_F00D, 20);
        checks++;
        if (lat != 5 || sreq_or !== 2'b10) begin
            errors++; $display("FAIL b2b_wait: latency %0d s_req=%b, required 5/10", lat, sreq_or);
        end
        run_a(1'b0, 32'h0000_5520, '0, 4'h0, 1'b0, 32'h0BAD_F00D, 20);
        checks++;
        if (lat != 3 || sreq_or !== 2'b01) begin
            errors++; $display("FAIL b2b_default: latency %0d s_req=%b, required 3/01", lat, sreq_or);
        end
        model_rdata = 32'h0BAD_F00D;
        dly[1] = 0;
    endtask

    task automatic test_reset_midtxn();
        int acks = 0;
        dly[0] = 6;
        @(negedge clk);
        m_req_a = 1'b1; m_we_a = 1'b0; m_addr_a = 32'h0000_0010;
        @(posedge clk); #1;
        checks++;
        if (s_req_a !== 2'b01) begin
            errors++; $display("FAIL midtxn_busy: s_req=%b, required 01", s_req_a);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (s_req_a !== 2'b00 || err_cnt_a !== 8'd0) begin
            errors++; $display("FAIL midtxn_async: s_req=%b err_cnt=%0d, required 00/0", s_req_a, err_cnt_a);
        end
        m_req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            if (m_ack_a !== 1'b0) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++; $display("FAIL midtxn_noack: %0d m_ack cycles after reset, required 0", acks);
        end
        dly[0] = 0; rd0 = 32'h600D_0001;
        run_a(1'b0, 32'h0000_0010, '0, 4'h0, 1'b0, 32'h600D_0001, 20);
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL midtxn_recover: latency %0d, required 3", lat);
        end
    endtask

    task automatic test_err_saturate();
        logic [31:0] a;
        for (int i = 0; i < 256; i++) begin
            a = {16'h0000, 8'h30, 8'(i)};
            run_b(a, 20);
            if (i == 253) begin
                checks++;
                if (err_cnt_b !== 8'hfe) begin
                    errors++; $display("FAIL errcnt_254: err_cnt=%h, required fe", err_cnt_b);
                end
            end
        end
        checks++;
        if (err_cnt_b !== 8'hff || err_addr_b !== 32'h0000_30ff) begin
            errors++; $display("FAIL errcnt_sat: err_cnt=%h err_addr=%h, required ff/000030ff", err_cnt_b, err_addr_b);
        end
        run_b(32'h0000_3abc, 20);
        checks++;
        if (err_cnt_b !== 8'hff || err_addr_b !== 32'h0000_3abc) begin
            errors++; $display("FAIL errcnt_hold: err_cnt=%h err_addr=%h, required ff/00003abc", err_cnt_b, err_addr_b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            dly[i] = 0; noack[i] = 0; wcnt[i] = 0;
        end
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_late_ack();
        test_unmapped();
        test_back_to_back();
        test_reset_midtxn();
        test_err_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
